// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: processor-side master for a word-addressed, byte-enabled
// data memory. Takes one load/store at a time, rejects misaligned requests,
// drives registered memory-side signals for exactly one ACCESS cycle and
// returns zero/sign-extended load data.
//
// state  | meaning
// IDLE   | ready, waiting for i_req
// ACCESS | memory cycle: dm_be/dm_we valid, load data captured at end
// DONE   | o_done pulse
// ERR    | o_misaligned pulse, no memory activity
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req / o_ready     request valid / unit idle and accepting
//   i_wr, i_size,       store flag, size (00 b, 01 h, 10 w, 11 illegal),
//   i_sext              sign-extend for byte/half loads
//   i_addr, i_wdata     byte address, right-justified store data
//   o_rdata             extended load result, held until the next load
//   o_done              one-cycle completion pulse
//   o_misaligned        one-cycle rejection pulse
//   o_dm_addr, o_dm_be, memory word address, byte enable,
//   o_dm_din, o_dm_we   write data, write enable (all registered)
//   i_dm_dout           combinational read word from memory
module dm_access_ctrl #(
   parameter int ADDR_HI = 11
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req,
   output logic               o_ready,
   input  logic               i_wr,
   input  logic [1:0]         i_size,
   input  logic               i_sext,
   input  logic [31:0]        i_addr,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        o_rdata,
   output logic               o_done,
   output logic               o_misaligned,
   output logic [ADDR_HI-2:0] o_dm_addr,
   output logic [3:0]         o_dm_be,
   output logic [31:0]        o_dm_din,
   output logic               o_dm_we,
   input  logic [31:0]        i_dm_dout
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_wr;
   logic [1:0]          r_size;
   logic                r_sext;
   logic [1:0]          r_addr_lo;
   logic [31:0]         r_rdata;
   logic [ADDR_HI-2:0]  r_dm_addr;
   logic [3:0]          r_dm_be;
   logic [31:0]         r_dm_din;
   logic                r_dm_we;
   logic                w_accept;
   logic                w_misaligned;
   logic [3:0]          w_be;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load;
   logic                w_unused;

   // Address bits above ADDR_HI are deliberately dropped (no range fault).
   assign w_unused = ^{i_addr[31:ADDR_HI+1]};

   assign w_accept     = (r_state == S_IDLE) && i_req;
   assign w_misaligned = (i_size == 2'b11) ||
                         ((i_size == 2'b01) && i_addr[0]) ||
                         ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));

   always_comb begin
      w_be = 4'b1111;
      case (i_size)
         2'b00:   w_be = 4'b0001 << i_addr[1:0];
         2'b01:   w_be = i_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_ready      = 1'b0;
      o_done       = 1'b0;
      o_misaligned = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_req) w_next = w_misaligned ? S_ERR : S_ACCESS;
         end
         S_ACCESS: w_next = S_DONE;
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         S_ERR: begin
            o_misaligned = 1'b1;
            w_next       = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Load lane selection uses the latched request, since i_addr may have
   // moved on by the time the memory answers.
   always_comb begin
      w_byte = i_dm_dout[7:0];
      case (r_addr_lo)
         2'd0: w_byte = i_dm_dout[7:0];
         2'd1: w_byte = i_dm_dout[15:8];
         2'd2: w_byte = i_dm_dout[23:16];
         2'd3: w_byte = i_dm_dout[31:24];
         default: w_byte = i_dm_dout[7:0];
      endcase
      w_half = r_addr_lo[1] ? i_dm_dout[31:16] : i_dm_dout[15:0];
      case (r_size)
         2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
         default: w_load = i_dm_dout;
      endcase
   end

   // Memory-side signals are loaded on the accepting edge so they are
   // registered and valid for the whole ACCESS cycle; any other edge
   // (including reset) drops the strobes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr      <= 1'b0;
         r_size    <= 2'b00;
         r_sext    <= 1'b0;
         r_addr_lo <= 2'b00;
         r_rdata   <= 32'h0;
         r_dm_addr <= '0;
         r_dm_be   <= 4'b0000;
         r_dm_din  <= 32'h0;
         r_dm_we   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr      <= i_wr;
            r_size    <= i_size;
            r_sext    <= i_sext;
            r_addr_lo <= i_addr[1:0];
         end
         if (w_accept && !w_misaligned) begin
            r_dm_addr <= i_addr[ADDR_HI:2];
            r_dm_be   <= w_be;
            r_dm_din  <= i_wdata;
            r_dm_we   <= i_wr;
         end else begin
            r_dm_be   <= 4'b0000;
            r_dm_we   <= 1'b0;
         end
         if ((r_state == S_ACCESS) && !r_wr) r_rdata <= w_load;
      end
   end

   assign o_rdata   = r_rdata;
   assign o_dm_addr = r_dm_addr;
   assign o_dm_be   = r_dm_be;
   assign o_dm_din  = r_dm_din;
   assign o_dm_we   = r_dm_we;

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req = 1'b0;
   logic        i_wr = 1'b0;
   logic [1:0]  i_size = 2'b00;
   logic        i_sext = 1'b0;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wdata = 32'h0;
   logic        o_ready, o_done, o_misaligned, o_dm_we;
   logic [31:0] o_rdata, o_dm_din, i_dm_dout;
   logic [9:0]  o_dm_addr;
   logic [3:0]  o_dm_be;

   dm_access_ctrl #(.ADDR_HI(11)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_ready(o_ready),
      .i_wr(i_wr), .i_size(i_size), .i_sext(i_sext), .i_addr(i_addr),
      .i_wdata(i_wdata), .o_rdata(o_rdata), .o_done(o_done),
      .o_misaligned(o_misaligned), .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be),
      .o_dm_din(o_dm_din), .o_dm_we(o_dm_we), .i_dm_dout(i_dm_dout)
   );

   always #5 i_clk = ~i_clk;

   // Memory model: byte lanes take din[7:0] for byte writes, the matching
   // half of din[15:0] for half writes, and the full word otherwise.
   logic [31:0] mem [0:1023];
   logic        mem_ready = 1'b0;
   assign i_dm_dout = mem[o_dm_addr];

   always @(posedge i_clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         for (int i = 0; i < 12; i++) mem[32'h40 + i] <= 32'h1000_0000 + i;
         mem_ready <= 1'b1;
      end else if (o_dm_we) begin
         for (int i = 0; i < 4; i++) begin
            if (o_dm_be[i]) begin
               if (o_dm_be == 4'b1111)
                  mem[o_dm_addr][8*i +: 8] <= o_dm_din[8*i +: 8];
               else if (o_dm_be == 4'b0011 || o_dm_be == 4'b1100)
                  mem[o_dm_addr][8*i +: 8] <= o_dm_din[8*(i%2) +: 8];
               else
                  mem[o_dm_addr][8*i +: 8] <= o_dm_din[7:0];
            end
         end
      end
   end

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request from idle. Expected completion is queued at drive time and
   // popped when the DUT pulses done or misaligned.
   task automatic access(input logic wr, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic err, input logic [31:0] load_val);
      exp_t e;
      int   lat;
      logic seen_we;
      @(negedge i_clk);
      chk("ready_idle", o_ready, 1);
      i_req = 1'b1; i_wr = wr; i_size = size; i_sext = sext; i_addr = addr; i_wdata = wdata;
      e.err = err;
      if (!err && !wr) last_rd = load_val;
      e.rdata = last_rd;
      sb.push_back(e);
      @(posedge i_clk);
      #1 i_req = 1'b0;
      lat = -1;
      seen_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         if (o_dm_we) seen_we = 1'b1;
         if (!err && k == 0) begin
            chk("acc_ready", o_ready, 0);
            chk("acc_we", o_dm_we, wr);
            chk("acc_be", o_dm_be, be);
            chk("acc_addr", o_dm_addr, addr[11:2]);
            chk("acc_din", o_dm_din, wdata);
         end
         if (o_done || o_misaligned) begin
            lat = k;
            break;
         end
      end
      chk("event_seen", lat >= 0, 1);
      if (lat >= 0 && sb.size() > 0) begin
         e = sb.pop_front();
         chk("latency", lat, e.err ? 0 : 1);
         chk("done", o_done, !e.err);
         chk("misaligned", o_misaligned, e.err);
         chk("rdata", o_rdata, e.rdata);
         chk("end_we", o_dm_we, 0);
         chk("end_be", o_dm_be, 0);
         if (e.err) chk("err_no_write", seen_we, 0);
      end
   endtask

   initial begin
      exp_t e;
      int   n_done;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_ready", o_ready, 1);
      chk("rst_done", o_done, 0);
      chk("rst_mis", o_misaligned, 0);
      chk("rst_we", o_dm_we, 0);
      chk("rst_be", o_dm_be, 0);
      chk("rst_addr", o_dm_addr, 0);
      chk("rst_din", o_dm_din, 0);
      chk("rst_rdata", o_rdata, 0);
      i_rst = 1'b0;

      // word store / load
      access(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 4'b1111, 0, 0);
      access(0, 2'b10, 0, 32'h010, 32'h0,        4'b1111, 0, 32'hDEADBEEF);
      // byte lanes: word becomes A5ADBEEF
      access(1, 2'b00, 0, 32'h013, 32'hFFFFFFA5, 4'b1000, 0, 0);
      access(0, 2'b00, 1, 32'h013, 32'h0,        4'b1000, 0, 32'hFFFFFFA5);
      access(0, 2'b00, 0, 32'h013, 32'h0,        4'b1000, 0, 32'h000000A5);
      access(0, 2'b00, 1, 32'h012, 32'h0,        4'b0100, 0, 32'hFFFFFFAD);
      access(0, 2'b00, 1, 32'h010, 32'h0,        4'b0001, 0, 32'hFFFFFFEF);
      // halfwords: word 8 becomes 80011234
      access(1, 2'b01, 0, 32'h022, 32'h00008001, 4'b1100, 0, 0);
      access(1, 2'b01, 0, 32'h020, 32'h55551234, 4'b0011, 0, 0);
      access(0, 2'b01, 1, 32'h022, 32'h0,        4'b1100, 0, 32'hFFFF8001);
      access(0, 2'b01, 0, 32'h022, 32'h0,        4'b1100, 0, 32'h00008001);
      access(0, 2'b01, 0, 32'h020, 32'h0,        4'b0011, 0, 32'h00001234);
      access(0, 2'b01, 1, 32'h020, 32'h0,        4'b0011, 0, 32'h00001234);
      // word load ignores sext; upper address bits ignored
      access(0, 2'b10, 1, 32'hFFFF_F010, 32'h0,  4'b1111, 0, 32'hA5ADBEEF);
      // misaligned requests leave rdata and memory untouched
      access(0, 2'b10, 0, 32'h012, 32'h0,        4'b0000, 1, 0);
      access(1, 2'b01, 0, 32'h021, 32'h0000BEEF, 4'b0000, 1, 0);
      access(1, 2'b11, 0, 32'h010, 32'h12345678, 4'b0000, 1, 0);
      access(0, 2'b10, 0, 32'h020, 32'h0,        4'b1111, 0, 32'h80011234);
      access(0, 2'b10, 0, 32'h010, 32'h0,        4'b1111, 0, 32'hA5ADBEEF);

      // back-pressure: req held high, address changes every cycle
      @(negedge i_clk);
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0 && o_done) begin
            n_done++;
            chk("bp_done_slot", c % 3, 2);
            chk("bp_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("bp_rdata", o_rdata, e.rdata);
            end
         end
         if (c < 9) begin
            i_req = 1'b1; i_wr = 1'b0; i_size = 2'b10; i_sext = 1'b0;
            i_addr = 32'h100 + 4 * c;
            if (c % 3 == 0) begin
               e.err = 1'b0;
               e.rdata = 32'h1000_0000 + c;
               sb.push_back(e);
            end
         end else begin
            i_req = 1'b0;
         end
         @(negedge i_clk);
      end
      chk("bp_count", n_done, 3);
      chk("bp_sb_empty", sb.size(), 0);

      // reset during the ACCESS cycle of a store
      i_req = 1'b1; i_wr = 1'b1; i_size = 2'b10; i_addr = 32'h030; i_wdata = 32'hCAFEF00D;
      @(negedge i_clk);
      i_req = 1'b0;
      chk("mid_acc_we", o_dm_we, 1);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("mid_rst_we", o_dm_we, 0);
      chk("mid_rst_ready", o_ready, 1);
      chk("mid_rst_done", o_done, 0);
      chk("mid_rst_rdata", o_rdata, 0);
      i_rst = 1'b0;
      n_done = 0;
      repeat (3) begin
         @(negedge i_clk);
         if (o_done) n_done++;
      end
      chk("mid_rst_no_done", n_done, 0);
      access(0, 2'b10, 0, 32'h010, 32'h0, 4'b1111, 0, 32'hA5ADBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Processor-side master for the word-addressed, byte-enabled data memory. Accepts one load/store request at a time from the pipeline and checks alignment. Produces the memory's word address, byte-enable, write data and write-enable. For loads it extracts, zero-extends or sign-extends the addressed byte or halfword from the returned word. Sits between the MEM stage and the data memory; all memory-side outputs are registered.

Parameters:
ADDR_HI, 11, top byte-address bit forwarded to memory; the memory word address is addr[ADDR_HI:2].

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  1  request valid; sampled only when ready=1
ready  out  1  unit idle and accepting a request
wr  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  32  byte address
wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rdata  out  32  extended load result; valid when done=1 after a load, held until the next load completes
done  out  1  one-cycle pulse on successful completion
misaligned  out  1  one-cycle pulse when a request is rejected
dm_addr  out  ADDR_HI-1  word address to memory (addr[ADDR_HI:2])
dm_be  out  4  byte enable to memory
dm_din  out  32  write data to memory
dm_we  out  1  memory write enable
dm_dout  in  32  combinational read word from memory at dm_addr

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; ready=1; done=0; misaligned=0; dm_we=0; dm_be=0000; dm_addr=0; dm_din=0; rdata=0. Reset takes priority over every other event. A reset during ACCESS aborts the access: dm_we is 0 from the next cycle and no done pulse is produced.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - ready=1.
  - On req=1, latch wr, size, sext, addr and wdata.
  - If the request is misaligned, go to ERR. Misaligned means any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]≠00.
  - Otherwise go to ACCESS.
  - req=0 stays in IDLE.
- ACCESS (exactly one cycle):
  - ready=0.
  - dm_addr = latched addr[ADDR_HI:2].
  - dm_be:
    - byte: 0001 << addr[1:0].
    - half: 0011 if addr[1]=0, 1100 if addr[1]=1.
    - word: 1111.
  - dm_din = latched wdata unshifted. The memory does lane steering from din[7:0] / din[15:0].
  - dm_we=1 only if wr=1.
  - For a load, at the end of the cycle, register rdata from dm_dout:
    - byte lane k = addr[1:0]: dm_dout[8k+7:8k].
    - half: dm_dout[31:16] if addr[1]=1, else dm_dout[15:0].
    - word: dm_dout unchanged.
    - Byte and half results are extended to 32 bits by sext; sext is ignored for word loads.
  - Next state: DONE.
- DONE: done=1, ready=0, dm_we=0, dm_be=0000. Next state: IDLE.
- ERR: misaligned=1, ready=0, no memory write, rdata unchanged. Next state: IDLE.
- Outside ACCESS: dm_we=0 and dm_be=0000; dm_addr and dm_din hold their last values.
- Latency: a request accepted at edge T does its access in cycle T+1, pulses done in cycle T+2, and ready returns in cycle T+3. Throughput is one access per 3 cycles.
- A store never modifies rdata.
- req while ready=0 is ignored; it is not queued.
- Address bits above ADDR_HI are ignored; there is no range fault.
- done and misaligned are never asserted in the same cycle.

Test Plan:
- Store word then load word: sw 0xDEADBEEF to 0x010 → ACCESS with dm_addr=4, dm_be=1111, dm_we=1, done 2 cycles after accept. lw from 0x010 → rdata=0xDEADBEEF.
- Byte lanes: sb 0xA5 to 0x013 → dm_be=1000, dm_din[7:0]=0xA5. lb from 0x013 with sext=1 → 0xFFFFFFA5. lbu from the same address → 0x000000A5.
- Halfwords: sh 0x8001 to 0x022 → dm_be=1100. lh → 0xFFFF8001. lhu → 0x00008001. lhu from 0x020 returns the low half.
- Misalignment: lw from 0x012, sh to 0x021, and size=11 → each pulses misaligned, never drives dm_we=1, never pulses done, and leaves rdata unchanged.
- Back-pressure: hold req=1 continuously with changing addr → only requests sampled while ready=1 execute, one per 3 cycles.
- Reset mid-access: assert rst in the ACCESS cycle of a sw → dm_we=0, ready=1 and done=0 on the following cycle. A later lw of that word shows the memory was not updated if rst was asserted before the write edge.
